// File: rtl/matmul_sequencer_if.sv
// Bus bundle between the matmul sequencer and its environment.
// The environment is the host, the operand memories and the MAC datapath.
// The master side is the sequencer; the slave side is the environment.
interface matmul_sequencer_if #(
   parameter int DW = 4,
   parameter int RW = 10,
   parameter int AW = 2
);
   logic              start;
   logic              busy;
   logic              done;
   logic [AW-1:0]     w_addr;
   logic [AW-1:0]     x_addr;
   logic              rd_en;
   logic [3*DW-1:0]   w_rdata;
   logic [3*DW-1:0]   x_rdata;
   logic [DW-1:0]     data_w1;
   logic [DW-1:0]     data_w2;
   logic [DW-1:0]     data_w3;
   logic [DW-1:0]     data_x1;
   logic [DW-1:0]     data_x2;
   logic [DW-1:0]     data_x3;
   logic [8:0]        load;
   logic [8:0]        clear;
   logic              unload_res;
   logic [RW-1:0]     mm_data_out;
   logic [RW-1:0]     res_data;
   logic [3:0]        res_idx;
   logic              res_valid;

   modport master (
      input  start, w_rdata, x_rdata, mm_data_out,
      output busy, done, w_addr, x_addr, rd_en,
             data_w1, data_w2, data_w3, data_x1, data_x2, data_x3,
             load, clear, unload_res, res_data, res_idx, res_valid
   );

   modport slave (
      output start, w_rdata, x_rdata, mm_data_out,
      input  busy, done, w_addr, x_addr, rd_en,
             data_w1, data_w2, data_w3, data_x1, data_x2, data_x3,
             load, clear, unload_res, res_data, res_idx, res_valid
   );
endinterface

// File: rtl/matmul_sequencer.sv
// Control sequencer for the 3x3 MAC-array matrix multiplier.
// Each operation runs the steps CLEAR, then FETCH of three operand
// steps, then DRAIN, then UNLOAD of nine results, then DONE.
module matmul_sequencer #(
   parameter int DW = 4,
   parameter int RW = 10,
   parameter int AW = 2
) (
   input  logic               clk,
   input  logic               rst,
   matmul_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_UNLOAD, S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     k_q, k_d;
   logic [3:0]     idx_q, idx_d;
   logic           rd_en;
   logic           v1_q, v2_q;
   logic [DW-1:0]  w1_q, w2_q, w3_q, x1_q, x2_q, x3_q;
   logic [RW-1:0]  res_data_q;
   logic [3:0]     res_idx_q;
   logic           res_valid_q;

   // State and step/index counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         idx_q   <= idx_d;
      end
   end

   // Next state; k counts FETCH steps and then reuses for the two DRAIN cycles
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE:   if (bus.start) state_d = S_CLEAR;
         S_CLEAR:  begin
            state_d = S_FETCH;
            k_d     = '0;
         end
         S_FETCH:  begin
            if (k_q == 2'd2) begin
               state_d = S_DRAIN;
               k_d     = '0;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         S_DRAIN:  begin
            if (k_q == 2'd1) begin
               state_d = S_UNLOAD;
               k_d     = '0;
               idx_d   = '0;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         S_UNLOAD: begin
            if (idx_q == 4'd8) begin
               state_d = S_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         S_DONE:   state_d = S_IDLE;
         default:  begin
            state_d = S_IDLE;
            k_d     = '0;
            idx_d   = '0;
         end
      endcase
   end

   assign rd_en = (state_q == S_FETCH);

   // Two-stage read-valid pipeline: v1 marks rdata valid, v2 marks data regs valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         w1_q <= '0;
         w2_q <= '0;
         w3_q <= '0;
         x1_q <= '0;
         x2_q <= '0;
         x3_q <= '0;
      end else begin
         v1_q <= rd_en;
         v2_q <= v1_q;
         if (v1_q) begin
            w1_q <= bus.w_rdata[DW-1:0];
            w2_q <= bus.w_rdata[2*DW-1:DW];
            w3_q <= bus.w_rdata[3*DW-1:2*DW];
            x1_q <= bus.x_rdata[DW-1:0];
            x2_q <= bus.x_rdata[2*DW-1:DW];
            x3_q <= bus.x_rdata[3*DW-1:2*DW];
         end
      end
   end

   // Result capture; the datapath index is not trusted, so res_idx comes from idx
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_data_q  <= '0;
         res_idx_q   <= '0;
         res_valid_q <= 1'b0;
      end else begin
         res_valid_q <= (state_q == S_UNLOAD);
         if (state_q == S_UNLOAD) begin
            res_data_q <= bus.mm_data_out;
            res_idx_q  <= idx_q;
         end
      end
   end

   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.rd_en      = rd_en;
   assign bus.w_addr     = rd_en ? AW'(k_q) : '0;
   assign bus.x_addr     = rd_en ? AW'(k_q) : '0;
   assign bus.data_w1    = w1_q;
   assign bus.data_w2    = w2_q;
   assign bus.data_w3    = w3_q;
   assign bus.data_x1    = x1_q;
   assign bus.data_x2    = x2_q;
   assign bus.data_x3    = x3_q;
   assign bus.load       = {9{v2_q}};
   assign bus.clear      = {9{state_q == S_CLEAR}};
   assign bus.unload_res = (state_q == S_UNLOAD);
   assign bus.res_data   = res_data_q;
   assign bus.res_idx    = res_idx_q;
   assign bus.res_valid  = res_valid_q;
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Control block for the 3x3 MAC-array matrix multiplier (nine MACs, 4-bit operands, 10-bit accumulators, serial unload port).
- On a start pulse it clears the nine accumulators and fetches A columns and B rows from two 12-bit-wide operand memories.
- It drives the row/column operand buses and load vector for three accumulate steps, then unloads the nine results as an indexed valid-qualified stream.
- It sits between the host/operand memories and the multiplier datapath.

Parameters:
- DW, 4, operand element width; memory words are 3*DW bits.
- RW, 10, result width; worst case 3*15*15=675 fits in 10 bits.
- AW, 2, operand memory address width; addresses 0..2 used.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- busy  out  1  high from the cycle after an accepted start until DONE is left
- done  out  1  one-cycle pulse in DONE state
- w_addr  out  AW  A memory address; word k = column k of A: [DW-1:0]=A[0][k], [2DW-1:DW]=A[1][k], [3DW-1:2DW]=A[2][k]
- x_addr  out  AW  B memory address; word k = row k of B: [DW-1:0]=B[k][0] .. [3DW-1:2DW]=B[k][2]
- rd_en  out  1  read strobe to both memories; rdata valid exactly one cycle later
- w_rdata  in  3*DW  A memory read data
- x_rdata  in  3*DW  B memory read data
- data_w1, data_w2, data_w3  out  DW each  registered A column elements to MAC rows 1..3
- data_x1, data_x2, data_x3  out  DW each  registered B row elements to MAC columns 1..3
- load  out  9  MAC accumulate enables; bit r*3+c drives MAC(r+1,c+1)
- clear  out  9  MAC accumulator clears, same bit mapping
- unload_res  out  1  advances the datapath unload index each cycle high
- mm_data_out  in  RW  datapath result output (currently indexed result)
- res_data  out  RW  captured result
- res_idx  out  4  result index 0..8 (row-major: idx = r*3+c)
- res_valid  out  1  res_data/res_idx valid this cycle

Behaviour:
- Reset:
  - State IDLE; all outputs 0, including addresses, data_* regs, load, clear, unload_res, res_* and counters.
  - rst does not clear the datapath accumulators; every operation begins with CLEAR.
  - rst mid-operation aborts immediately. done is not pulsed. The next start restarts from CLEAR.
- States: IDLE, CLEAR, FETCH, DRAIN, UNLOAD, DONE.
- Sequence (cycle 0 = edge where start is sampled high in IDLE):
  - Cycle 1, CLEAR: clear=9'h1FF, load=0.
  - Cycles 2-4, FETCH, k=0,1,2: rd_en=1, w_addr=x_addr=k.
  - Cycles 3-5: rdata for k valid; captured into data_w*/data_x* at the end of that cycle.
  - Cycles 4-6: data_* hold step k with load=9'h1FF. Two-stage valid pipeline gates load; load is never asserted with stale data.
  - Cycles 5-6, DRAIN: no reads; pipeline empties.
  - Cycles 7-15, UNLOAD: unload_res=1, internal idx 0..8. mm_data_out is captured each UNLOAD cycle.
  - Cycles 8-16: res_valid=1, res_idx=0..8.
  - Cycle 16, DONE: done=1, busy=1. Cycle 17: IDLE, busy=0.
  - Total latency start to done: 16 cycles.
- load and clear are never high in the same cycle. clear is high only in CLEAR.
- data_w*/data_x* hold their last value outside load cycles.
- start while busy or in DONE is ignored, not queued. start in the IDLE cycle right after DONE is accepted.
- The datapath unload index saturates at 9 and is not cleared by this block. Exactly 9 unload_res cycles are issued per operation. The controller's res_idx is authoritative.
- No arithmetic in this block; counters k (2 bits) and idx (4 bits) wrap to 0 on state exit.

Test Plan:
- Reset values: assert rst mid-FETCH. Required: all outputs 0 asynchronously, state IDLE, no done. Next start yields a full 16-cycle sequence.
- Identity x B: A=I, B=[[1,2,3],[4,5,6],[7,8,9]]. Required: res_valid cycles 8-16 with res_idx 0..8 and res_data 1..9; done at cycle 16.
- Max values: all elements 15. Required: every res_data = 675 with no overflow.
- Timing: check the exact cycles for clear=1FF (1), rd_en with addr 0,1,2 (2-4), load=1FF (4-6), unload_res (7-15).
- Back-to-back: second start at cycle 5 is ignored. A start at cycle 17 runs a new operation with results independent of the first (CLEAR effective).
- Protocol invariants: load&clear never overlap, and load is never high outside cycles 4-6 relative to start.
